prbs_frame_serializer: RTL and testbench
========================================

PRBS_FRAME_SERIALIZER -- requirements
Module: prbs_frame_serializer

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 10, bits per word.
REQ-002 SHALL have parameter FRAME_WORDS, default 20, words per frame.
REQ-003 SHALL have parameter POLY_LENGTH, default 9, LFSR length.
REQ-004 SHALL have parameter POLY_TAP, default 5, second feedback tap (1-based).
REQ-005 SHALL have parameter INV_PATTERN, default 1, inverts PRBS output bits when 1.
REQ-006 SHALL have parameter DIV_WIDTH, default 4, width of speed_ctrl.
REQ-007 SHALL provide port clk  input  1  single clock; all logic on its rising edge.
REQ-008 SHALL provide port rst_n  input  1  reset, asynchronous, active-low.
REQ-009 SHALL provide port start  input  1  one-cycle pulse requesting a frame.
REQ-010 SHALL provide port abort  input  1  synchronous frame cancel.
REQ-011 SHALL provide port continuous  input  1  1 = restart a new frame with no gap at frame end.
REQ-012 SHALL provide port mode  input  2  00 PRBS, 01 alternating 1010..., 10 fixed_word repeated, 11 all zeros.
REQ-013 SHALL provide port fixed_word  input  WORD_WIDTH  word for mode 10.
REQ-014 SHALL provide port speed_ctrl  input  DIV_WIDTH  bit period = speed_ctrl+1 clocks.
REQ-015 SHALL provide port serial_out  output  1  serial data, registered.
REQ-016 SHALL provide port bit_strobe  output  1  high on the first clock of each bit period.
REQ-017 SHALL provide port busy  output  1  high while a frame is being sent.
REQ-018 SHALL provide port frame_done  output  1  one-cycle pulse after the last bit of a frame.

Function
REQ-019 SHALL implement FSM states IDLE, SEND, DONE.
REQ-020 IDLE: start=1 -> SEND; mode, speed_ctrl, fixed_word captured at that edge and held for the frame; LFSR reseeded to all ones.
REQ-021 First bit SHALL appear on serial_out at the edge after start is sampled; busy and bit_strobe go high at that same edge.
REQ-022 Each bit SHALL be held exactly speed_ctrl+1 clocks; speed_ctrl=0 gives one bit per clock.
REQ-023 A frame SHALL be FRAME_WORDS*WORD_WIDTH bits; frame duration = FRAME_WORDS*WORD_WIDTH*(speed_ctrl+1) clocks.
REQ-024 PRBS bit = LFSR[POLY_LENGTH-1] XOR INV_PATTERN; per bit, LFSR shifts left with LSB <= LFSR[POLY_LENGTH-1] XOR LFSR[POLY_TAP-1].
REQ-025 Mode 10 SHALL send fixed_word MSB first, repeated FRAME_WORDS times; mode 01 SHALL start with 1; mode 11 sends 0; INV_PATTERN SHALL apply to mode 00 only.
REQ-026 After the last bit period: continuous=0 -> DONE (frame_done=1 for one cycle, busy=0, serial_out=0) -> IDLE; continuous=1 -> new frame starts at the next edge, re-capturing inputs and reseeding, no idle cycle, frame_done still pulses for one cycle.
REQ-027 start while in SEND or DONE SHALL be ignored.
REQ-028 abort=1 in SEND SHALL return to IDLE at the next edge: busy=0, serial_out=0, no frame_done; abort has priority over start and continuous.
REQ-029 In IDLE serial_out SHALL be 0 and bit_strobe 0.
REQ-030 Bit and word counters SHALL wrap to 0 at frame start; no counter overflow for any parameter set.

Reset
REQ-031 rst_n=0 SHALL force immediately: state IDLE, serial_out=0, bit_strobe=0, busy=0, frame_done=0, counters 0, LFSR all ones.
REQ-032 rst_n low mid-frame SHALL abandon the frame with no frame_done; after release the block waits for a new start.

Verification
REQ-033 Defaults, mode 00, speed_ctrl=0, one start pulse -> first 9 serial_out bits 0 (seed ones inverted), 200 bits total, busy high 200 cycles, frame_done one pulse on cycle 201.
REQ-034 Mode 10, fixed_word=10'h2A5, speed_ctrl=3 -> bits 1010100101 repeated, each held 4 clocks, bit_strobe every 4th clock, frame length 800 clocks.
REQ-035 continuous=1 over two frames, mode 00 -> second frame bit-identical to first, zero idle cycles between, frame_done pulses once per frame.
REQ-036 abort asserted at bit 57 -> busy=0 and serial_out=0 next cycle, no frame_done; later start yields full normal frame.
REQ-037 start re-pulsed mid-frame, then rst_n pulsed low mid-frame -> first has no effect; reset clears all outputs asynchronously, no frame_done.
REQ-038 Parameters POLY_LENGTH=7, POLY_TAP=6, INV_PATTERN=0, continuous=1 -> PRBS period 127 bits confirmed by reference LFSR model.

Source files
------------

// File: rtl/prbs_frame_serializer.sv
// Frame serializer: sends FRAME_WORDS*WORD_WIDTH bits of PRBS, alternating,
// fixed-word or zero pattern, each bit held speed_ctrl+1 clocks.
//
// state | meaning
// IDLE  | waiting for start; outputs low
// SEND  | frame in progress; one bit per speed_ctrl+1 clocks
// DONE  | one-cycle frame_done pulse, then back to IDLE
module prbs_frame_serializer #(
  parameter int WORD_WIDTH  = 10,
  parameter int FRAME_WORDS = 20,
  parameter int POLY_LENGTH = 9,
  parameter int POLY_TAP    = 5,
  parameter int INV_PATTERN = 1,
  parameter int DIV_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  continuous,
  input  logic [1:0]            mode,
  input  logic [WORD_WIDTH-1:0] fixed_word,
  input  logic [DIV_WIDTH-1:0]  speed_ctrl,
  output logic                  serial_out,
  output logic                  bit_strobe,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int BIT_CW  = $clog2(WORD_WIDTH + 1);
  localparam int WORD_CW = $clog2(FRAME_WORDS + 1);
  localparam logic [BIT_CW-1:0]  LAST_BIT  = BIT_CW'(WORD_WIDTH - 1);
  localparam logic [WORD_CW-1:0] LAST_WORD = WORD_CW'(FRAME_WORDS - 1);
  localparam logic INV = (INV_PATTERN != 0);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t                 state_q, state_d;
  logic [POLY_LENGTH-1:0] lfsr_q;
  logic [BIT_CW-1:0]      bit_cnt_q;
  logic [WORD_CW-1:0]     word_cnt_q;
  logic [DIV_WIDTH-1:0]   div_cnt_q;
  logic [1:0]             mode_q;
  logic [DIV_WIDTH-1:0]   speed_q;
  logic [WORD_WIDTH-1:0]  fixed_q;
  logic [WORD_WIDTH-1:0]  fixed_sh_q;
  logic                   alt_q;

  logic bit_end, last_word_bit, frame_end;
  logic load, adv;
  logic serial_d, strobe_d, busy_d, done_d;
  logic [1:0]             src_mode;
  logic [POLY_LENGTH-1:0] src_lfsr;
  logic                   src_fixed, src_alt, gen_bit;

  function automatic logic [POLY_LENGTH-1:0] lfsr_step(input logic [POLY_LENGTH-1:0] v);
    return {v[POLY_LENGTH-2:0], v[POLY_LENGTH-1] ^ v[POLY_TAP-1]};
  endfunction

  assign bit_end       = (div_cnt_q == '0);
  assign last_word_bit = (bit_cnt_q == LAST_BIT);
  assign frame_end     = bit_end && last_word_bit && (word_cnt_q == LAST_WORD);

  // On a frame load the next bit comes from the live inputs and a fresh seed.
  always_comb begin
    src_mode  = load ? mode : mode_q;
    src_lfsr  = load ? '1 : lfsr_q;
    src_alt   = load ? 1'b1 : ~alt_q;
    src_fixed = load ? fixed_word[WORD_WIDTH-1]
                     : (last_word_bit ? fixed_q[WORD_WIDTH-1] : fixed_sh_q[WORD_WIDTH-1]);
    case (src_mode)
      2'b00:   gen_bit = src_lfsr[POLY_LENGTH-1] ^ INV;
      2'b01:   gen_bit = src_alt;
      2'b10:   gen_bit = src_fixed;
      default: gen_bit = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    adv      = 1'b0;
    serial_d = 1'b0;
    strobe_d = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SEND;
          load    = 1'b1;
        end
      end
      SEND: begin
        if (abort) begin
          state_d = IDLE;
        end else if (!bit_end) begin
          busy_d   = 1'b1;
          serial_d = serial_out;
        end else if (!frame_end) begin
          adv = 1'b1;
        end else begin
          done_d = 1'b1;
          if (continuous) load = 1'b1;
          else            state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (load || adv) begin
      busy_d   = 1'b1;
      strobe_d = 1'b1;
      serial_d = gen_bit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lfsr_q     <= '1;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      div_cnt_q  <= '0;
      mode_q     <= '0;
      speed_q    <= '0;
      fixed_q    <= '0;
      fixed_sh_q <= '0;
      alt_q      <= 1'b0;
      serial_out <= 1'b0;
      bit_strobe <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      serial_out <= serial_d;
      bit_strobe <= strobe_d;
      busy       <= busy_d;
      frame_done <= done_d;
      if (load) begin
        mode_q     <= mode;
        speed_q    <= speed_ctrl;
        fixed_q    <= fixed_word;
        fixed_sh_q <= fixed_word << 1;
        lfsr_q     <= lfsr_step('1);
        alt_q      <= 1'b1;
        bit_cnt_q  <= '0;
        word_cnt_q <= '0;
        div_cnt_q  <= speed_ctrl;
      end else if (adv) begin
        lfsr_q     <= lfsr_step(lfsr_q);
        alt_q      <= ~alt_q;
        div_cnt_q  <= speed_q;
        fixed_sh_q <= last_word_bit ? (fixed_q << 1) : (fixed_sh_q << 1);
        if (last_word_bit) begin
          bit_cnt_q  <= '0;
          word_cnt_q <= word_cnt_q + 1'b1;
        end else begin
          bit_cnt_q <= bit_cnt_q + 1'b1;
        end
      end else if (state_d == SEND) begin
        div_cnt_q <= div_cnt_q - 1'b1;
      end else begin
        lfsr_q     <= '1;
        bit_cnt_q  <= '0;
        word_cnt_q <= '0;
        div_cnt_q  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_prbs_frame_serializer.sv
// Directed bench for prbs_frame_serializer: default PRBS9 instance plus a
// PRBS7 (non-inverted) instance for period checking.
module tb_prbs_frame_serializer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, abort = 1'b0, continuous = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [9:0] fixed_word = '0;
  logic [3:0] speed_ctrl = '0;
  logic       serial_out, bit_strobe, busy, frame_done;

  logic       start2 = 1'b0;
  logic       serial_out2, bit_strobe2, busy2, frame_done2;

  int checks = 0;
  int errors = 0;
  bit exp9 [200];
  bit exp7 [200];

  always #5 clk = ~clk;

  prbs_frame_serializer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .continuous(continuous), .mode(mode), .fixed_word(fixed_word),
    .speed_ctrl(speed_ctrl), .serial_out(serial_out), .bit_strobe(bit_strobe),
    .busy(busy), .frame_done(frame_done)
  );

  prbs_frame_serializer #(.POLY_LENGTH(7), .POLY_TAP(6), .INV_PATTERN(0)) dut7 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(1'b0),
    .continuous(1'b1), .mode(2'b00), .fixed_word(10'h000),
    .speed_ctrl(4'h0), .serial_out(serial_out2), .bit_strobe(bit_strobe2),
    .busy(busy2), .frame_done(frame_done2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic build_models();
    logic [8:0] m9 = '1;
    logic [6:0] m7 = '1;
    for (int i = 0; i < 200; i++) begin
      exp9[i] = m9[8] ^ 1'b1;
      m9 = {m9[7:0], m9[8] ^ m9[4]};
      exp7[i] = m7[6];
      m7 = {m7[5:0], m7[6] ^ m7[5]};
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if ({serial_out, bit_strobe, busy, frame_done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 0000", {serial_out, bit_strobe, busy, frame_done});
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || serial_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy %b serial %b expected 0 0", busy, serial_out);
    end
  endtask

  task automatic test_prbs_frame(input string tag);
    int busy_cnt = 0;
    int zero_cnt = 0;
    mode = 2'b00; speed_ctrl = 4'd0; continuous = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      checks++;
      if (serial_out !== exp9[i] || bit_strobe !== 1'b1 || frame_done !== 1'b0) begin
        errors++;
        $display("FAIL %s bit %0d: serial %b strobe %b done %b expected %b 1 0",
                 tag, i, serial_out, bit_strobe, frame_done, exp9[i]);
      end
      if (busy === 1'b1) busy_cnt++;
      if (i < 9 && serial_out === 1'b0) zero_cnt++;
      tick();
    end
    checks++;
    if (zero_cnt != 9) begin
      errors++;
      $display("FAIL %s first9_zero: got %0d zeros expected 9", tag, zero_cnt);
    end
    checks++;
    if (busy_cnt != 200) begin
      errors++;
      $display("FAIL %s busy_len: got %0d expected 200", tag, busy_cnt);
    end
    checks++;
    if (frame_done !== 1'b1 || busy !== 1'b0 || serial_out !== 1'b0) begin
      errors++;
      $display("FAIL %s frame_end: done %b busy %b serial %b expected 1 0 0", tag, frame_done, busy, serial_out);
    end
    tick();
    checks++;
    if (frame_done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s after_done: done %b busy %b expected 0 0", tag, frame_done, busy);
    end
  endtask

  task automatic test_fixed_word();
    logic [9:0] pat = 10'b1010100101;
    int busy_cnt = 0;
    mode = 2'b10; fixed_word = 10'h2A5; speed_ctrl = 4'd3; continuous = 1'b0; start = 1'b1;
    tick();
    start = 1'b0; mode = 2'b00; fixed_word = 10'h000; speed_ctrl = 4'd0;
    for (int b = 0; b < 200; b++) begin
      for (int c = 0; c < 4; c++) begin
        checks++;
        if (serial_out !== pat[9 - (b % 10)] || bit_strobe !== (c == 0) || frame_done !== 1'b0) begin
          errors++;
          $display("FAIL fixed bit %0d clk %0d: serial %b strobe %b done %b expected %b %b 0",
                   b, c, serial_out, bit_strobe, frame_done, pat[9 - (b % 10)], (c == 0));
        end
        if (busy === 1'b1) busy_cnt++;
        tick();
      end
    end
    checks++;
    if (busy_cnt != 800) begin
      errors++;
      $display("FAIL fixed busy_len: got %0d expected 800", busy_cnt);
    end
    checks++;
    if (frame_done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL fixed frame_end: done %b busy %b expected 1 0", frame_done, busy);
    end
    tick();
  endtask

  task automatic test_alt_zero();
    mode = 2'b01; speed_ctrl = 4'd0; continuous = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      checks++;
      if (serial_out !== ((i % 2) == 0) || busy !== 1'b1) begin
        errors++;
        $display("FAIL alt bit %0d: serial %b busy %b expected %b 1", i, serial_out, busy, ((i % 2) == 0));
      end
      tick();
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || serial_out !== 1'b0) begin
      errors++;
      $display("FAIL start_in_done: busy %b serial %b expected 0 0", busy, serial_out);
    end
    tick();
    mode = 2'b11; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      checks++;
      if (serial_out !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL zero bit %0d: serial %b busy %b expected 0 1", i, serial_out, busy);
      end
      tick();
    end
    tick();
  endtask

  task automatic test_continuous();
    int done_cnt = 0;
    mode = 2'b00; speed_ctrl = 4'd0; continuous = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 400; i++) begin
      checks++;
      if (serial_out !== exp9[i % 200] || busy !== 1'b1 || frame_done !== (i == 200)) begin
        errors++;
        $display("FAIL cont bit %0d: serial %b busy %b done %b expected %b 1 %b",
                 i, serial_out, busy, frame_done, exp9[i % 200], (i == 200));
      end
      if (frame_done === 1'b1) done_cnt++;
      if (i == 200) continuous = 1'b0;
      tick();
    end
    if (frame_done === 1'b1) done_cnt++;
    checks++;
    if (done_cnt != 2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL cont done_pulses: got %0d busy %b expected 2 0", done_cnt, busy);
    end
    tick();
  endtask

  task automatic test_abort();
    int bad = 0;
    mode = 2'b00; speed_ctrl = 4'd0; continuous = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i <= 57; i++) begin
      checks++;
      if (serial_out !== exp9[i]) begin
        errors++;
        $display("FAIL abort_pre bit %0d: got %b expected %b", i, serial_out, exp9[i]);
      end
      if (i < 57) tick();
    end
    abort = 1'b1; start = 1'b1; continuous = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0; continuous = 1'b0;
    checks++;
    if ({busy, serial_out, bit_strobe, frame_done} !== 4'b0000) begin
      errors++;
      $display("FAIL abort_exit: got %b expected 0000", {busy, serial_out, bit_strobe, frame_done});
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      if (frame_done !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL abort_quiet: got %0d bad cycles expected 0", bad);
    end
    test_prbs_frame("after_abort");
  endtask

  task automatic test_restart_and_reset();
    int bad = 0;
    mode = 2'b00; speed_ctrl = 4'd0; continuous = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i <= 80; i++) begin
      checks++;
      if (serial_out !== exp9[i] || busy !== 1'b1) begin
        errors++;
        $display("FAIL restart bit %0d: serial %b busy %b expected %b 1", i, serial_out, busy, exp9[i]);
      end
      start = (i == 30);
      if (i < 80) tick();
    end
    start = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({serial_out, bit_strobe, busy, frame_done} !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset: got %b expected 0000", {serial_out, bit_strobe, busy, frame_done});
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (frame_done !== 1'b0 || busy !== 1'b0 || serial_out !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL post_reset_idle: got %0d bad cycles expected 0", bad);
    end
  endtask

  task automatic test_poly7();
    bit got [200];
    int per_err = 0;
    int ones = 0;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int i = 0; i < 200; i++) begin
      got[i] = serial_out2;
      checks++;
      if (serial_out2 !== exp7[i] || bit_strobe2 !== 1'b1) begin
        errors++;
        $display("FAIL prbs7 bit %0d: serial %b strobe %b expected %b 1", i, serial_out2, bit_strobe2, exp7[i]);
      end
      tick();
    end
    for (int i = 0; i < 73; i++) if (got[i + 127] != got[i]) per_err++;
    for (int i = 0; i < 127; i++) if (got[i]) ones++;
    checks++;
    if (per_err != 0) begin
      errors++;
      $display("FAIL prbs7_period: got %0d repeat mismatches expected 0", per_err);
    end
    checks++;
    if (ones != 64) begin
      errors++;
      $display("FAIL prbs7_ones: got %0d expected 64", ones);
    end
    checks++;
    if (frame_done2 !== 1'b1 || busy2 !== 1'b1) begin
      errors++;
      $display("FAIL prbs7_cont_done: done %b busy %b expected 1 1", frame_done2, busy2);
    end
  endtask

  initial begin
    build_models();
    test_reset();
    test_prbs_frame("prbs_default");
    test_fixed_word();
    test_alt_zero();
    test_continuous();
    test_abort();
    test_restart_and_reset();
    test_poly7();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
